// File: rtl/mult_hilo_ctrl_if.sv
// Bundle of pipeline-side and multiplier-side signals of the HI/LO multiply sequencer.
// master: pipeline plus multiplier datapath (drives ops and mul_result/mul_end).
// slave: the sequencer itself.
interface mult_hilo_ctrl_if;
  // Pipeline side
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic [31:0] rd_val;
  logic        busy;
  logic        timeout_err;
  // Multiplier datapath side
  logic        mul_work;
  logic [31:0] mul_lhs;
  logic [31:0] mul_rhs;
  logic [63:0] mul_result;
  logic        mul_end;
  // Architectural registers
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op_code, rs_val, rt_val, mul_result, mul_end,
    input  stall, rd_val, busy, timeout_err, mul_work, mul_lhs, mul_rhs, hi, lo
  );

  modport slave (
    input  op_valid, op_code, rs_val, rt_val, mul_result, mul_end,
    output stall, rd_val, busy, timeout_err, mul_work, mul_lhs, mul_rhs, hi, lo
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Sequencer between the MIPS control unit and an iterative 32x32 multiplier.
// Owns HI/LO, converts signed operands to magnitudes, runs the work/end
// handshake with a bounded wait, sign-corrects the product and stalls the
// pipeline while a multiply is in flight.
module mult_hilo_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7   // needs 2**CNT_W > TIMEOUT
) (
  input logic             Clk,
  input logic             reset,
  mult_hilo_ctrl_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpMthi  = 3'b011;
  localparam logic [2:0] OpMtlo  = 3'b100;
  localparam logic [2:0] OpMfhi  = 3'b101;
  localparam logic [2:0] OpMflo  = 3'b110;

  // Last WAIT count before giving up; the TIMEOUT-th WAIT cycle has count TIMEOUT-1.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StFix
  } state_e;

  state_e            state_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;
  logic [31:0]       lhs_q;
  logic [31:0]       rhs_q;
  logic [63:0]       prod_q;
  logic              neg_q;
  logic              work_q;
  logic              terr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              busy;
  logic              real_op;
  logic [31:0]       rs_mag;
  logic [31:0]       rt_mag;
  logic [63:0]       prod_fixed;
  logic [31:0]       rd_val;

  // Decode, operand magnitudes, sign fix-up and the combinational pipeline outputs.
  always_comb begin
    busy       = (state_q != StIdle);
    real_op    = (bus.op_code != 3'b000) && (bus.op_code != 3'b111);
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    rs_mag     = bus.rs_val[31] ? (~bus.rs_val + 32'd1) : bus.rs_val;
    rt_mag     = bus.rt_val[31] ? (~bus.rt_val + 32'd1) : bus.rt_val;
    prod_fixed = neg_q ? (~prod_q + 64'd1) : prod_q;
    rd_val     = 32'd0;
    if (bus.op_code == OpMfhi) begin
      rd_val = hi_q;
    end else if (bus.op_code == OpMflo) begin
      rd_val = lo_q;
    end
  end

  // Sequencer FSM with registered outputs; reset drops any in-flight multiply.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= StIdle;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      lhs_q   <= 32'd0;
      rhs_q   <= 32'd0;
      prod_q  <= 64'd0;
      neg_q   <= 1'b0;
      work_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // mul_work is only ever high for the single START cycle.
      work_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.op_valid) begin
            case (bus.op_code)
              OpMult: begin
                lhs_q   <= rs_mag;
                rhs_q   <= rt_mag;
                neg_q   <= bus.rs_val[31] ^ bus.rt_val[31];
                work_q  <= 1'b1;
                state_q <= StStart;
              end
              OpMultu: begin
                lhs_q   <= bus.rs_val;
                rhs_q   <= bus.rt_val;
                neg_q   <= 1'b0;
                work_q  <= 1'b1;
                state_q <= StStart;
              end
              OpMthi:  hi_q <= bus.rs_val;
              OpMtlo:  lo_q <= bus.rs_val;
              default: ;
            endcase
          end
        end
        StStart: begin
          // mul_end is deliberately not looked at here: it may still be high
          // from the previous operation.
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (bus.mul_end) begin
            // Completion wins over a timeout landing in the same cycle.
            prod_q  <= bus.mul_result;
            state_q <= StFix;
          end else if (cnt_q == CntLast) begin
            terr_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StFix: begin
          {hi_q, lo_q} <= prod_fixed;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.stall       = bus.op_valid & busy & real_op;
  assign bus.rd_val      = rd_val;
  assign bus.timeout_err = terr_q;
  assign bus.mul_work    = work_q;
  assign bus.mul_lhs     = lhs_q;
  assign bus.mul_rhs     = rhs_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: behavioural model of the HI/LO sequencer, a
// delay-programmable multiplier model, directed cases and random traffic.
module tb_mult_hilo_ctrl;

  localparam int TIMEOUT = 64;

  logic Clk;
  logic rst;
  mult_hilo_ctrl_if bus ();

  mult_hilo_ctrl #(
    .TIMEOUT (64),
    .CNT_W   (7)
  ) dut (
    .Clk   (Clk),
    .reset (rst),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // Multiplier model controls
  int   mdelay    = 2;   // cycles from the START cycle to the mul_end pulse, 0 = never
  logic end_level = 1'b0;
  logic end_pulse = 1'b0;
  assign bus.mul_end = end_pulse | end_level;

  // Behavioural model: architectural results plus age of the current multiply
  logic [31:0] m_hi = '0, m_lo = '0, m_lhs = '0, m_rhs = '0;
  logic [63:0] m_prod = '0;
  logic        m_busy = 1'b0, m_terr = 1'b0;
  int          m_age = 0;      // 1 = START cycle, 2..TIMEOUT+1 = waiting cycles
  int          m_end_age = 0;  // age at which mul_end was seen, 0 if not yet

  always @(posedge Clk) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_lhs <= '0; m_rhs <= '0; m_prod <= '0;
      m_busy <= 1'b0; m_terr <= 1'b0; m_age <= 0; m_end_age <= 0;
    end else if (!m_busy) begin
      if (bus.op_valid) begin
        case (bus.op_code)
          3'd1: begin
            m_busy <= 1'b1; m_age <= 1; m_end_age <= 0;
            m_lhs  <= bus.rs_val[31] ? (32'd0 - bus.rs_val) : bus.rs_val;
            m_rhs  <= bus.rt_val[31] ? (32'd0 - bus.rt_val) : bus.rt_val;
            m_prod <= longint'($signed(bus.rs_val)) * longint'($signed(bus.rt_val));
          end
          3'd2: begin
            m_busy <= 1'b1; m_age <= 1; m_end_age <= 0;
            m_lhs  <= bus.rs_val;
            m_rhs  <= bus.rt_val;
            m_prod <= {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
          end
          3'd3: m_hi <= bus.rs_val;
          3'd4: m_lo <= bus.rs_val;
          default: ;
        endcase
      end
    end else begin
      if (m_end_age != 0) begin
        {m_hi, m_lo} <= m_prod;
        m_busy       <= 1'b0;
      end else if (m_age >= 2 && bus.mul_end === 1'b1) begin
        m_end_age <= m_age;
        m_age     <= m_age + 1;
      end else if (m_age == TIMEOUT + 1) begin
        m_terr <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  // Multiplier datapath model: latches operands on mul_work, answers after mdelay.
  initial begin
    int          mcount;
    logic [63:0] mprod;
    mcount = 0;
    mprod  = '0;
    bus.mul_result = '0;
    forever begin
      @(negedge Clk);
      if (bus.mul_work === 1'b1 && mdelay != 0) begin
        mcount = mdelay;
        mprod  = {32'd0, bus.mul_lhs} * {32'd0, bus.mul_rhs};
      end
      @(posedge Clk);
      #1;
      end_pulse = 1'b0;
      if (mcount > 0) begin
        mcount--;
        if (mcount == 0) begin
          end_pulse      = 1'b1;
          bus.mul_result = mprod;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare_all();
    logic [31:0] exp_rd;
    logic        real_op;
    real_op = (bus.op_code != 3'd0) && (bus.op_code != 3'd7);
    chk("busy", bus.busy, m_busy);
    chk("stall", bus.stall, bus.op_valid & m_busy & real_op);
    chk("mul_work", bus.mul_work, m_busy && m_age == 1);
    chk("mul_lhs", bus.mul_lhs, m_lhs);
    chk("mul_rhs", bus.mul_rhs, m_rhs);
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
    chk("timeout_err", bus.timeout_err, m_terr);
    if (bus.op_valid && !m_busy) begin
      exp_rd = (bus.op_code == 3'd5) ? m_hi : (bus.op_code == 3'd6) ? m_lo : 32'd0;
      chk("rd_val", bus.rd_val, exp_rd);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    if (armed) compare_all();
    @(posedge Clk);
    #1;
  endtask

  task automatic present(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && bus.busy !== 1'b0; i++) tick();
    chk(name, bus.busy, 1'b0);
  endtask

  // Issue a multiply, leave START, then run until the sequencer is idle again.
  task automatic run_mul(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input int d);
    mdelay = d;
    present(op, rs, rt);
    tick();
    bus.op_valid = 1'b0;
    wait_idle("mul_done_bound");
  endtask

  initial begin
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd0;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    @(posedge Clk);
    #1;
    armed = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    chk("reset_busy", bus.busy, 1'b0);
    tick();

    // MULTU all-ones: single work pulse, unsigned product
    mdelay = 2;
    present(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    bus.op_valid = 1'b0;
    chk("multu_work_pulse", bus.mul_work, 1'b1);
    tick();
    chk("multu_work_drop", bus.mul_work, 1'b0);
    wait_idle("multu_bound");
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);

    // MULT -3 * 7
    mdelay = 3;
    present(3'd1, 32'hFFFF_FFFD, 32'd7);
    tick();
    bus.op_valid = 1'b0;
    chk("mult_neg_lhs", bus.mul_lhs, 32'd3);
    chk("mult_neg_rhs", bus.mul_rhs, 32'd7);
    wait_idle("mult_neg_bound");
    chk("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);

    // MULT most-negative squared
    mdelay = 1;
    present(3'd1, 32'h8000_0000, 32'h8000_0000);
    tick();
    bus.op_valid = 1'b0;
    chk("mult_min_lhs", bus.mul_lhs, 32'h8000_0000);
    chk("mult_min_rhs", bus.mul_rhs, 32'h8000_0000);
    wait_idle("mult_min_bound");
    chk("mult_min_hi", bus.hi, 32'h4000_0000);
    chk("mult_min_lo", bus.lo, 32'h0000_0000);

    // MFLO held behind a MULT
    mdelay = 4;
    present(3'd1, 32'd5, 32'hFFFF_FFFE);
    tick();
    present(3'd6, 32'd0, 32'd0);
    for (int i = 0; i < 200 && bus.stall !== 1'b0; i++) tick();
    chk("mflo_unstall", bus.stall, 1'b0);
    chk("mflo_value", bus.rd_val, 32'hFFFF_FFF6);
    tick();
    bus.op_valid = 1'b0;

    // MTHI behind a MULTU: hi stays until the MTHI is taken
    mdelay = 5;
    present(3'd2, 32'd2, 32'd3);
    tick();
    present(3'd3, 32'h0000_AAAA, 32'd0);
    tick();
    chk("mthi_blocked_hi", bus.hi, 32'hFFFF_FFFF);
    for (int i = 0; i < 200 && bus.stall !== 1'b0; i++) tick();
    tick();
    bus.op_valid = 1'b0;
    chk("mthi_late_hi", bus.hi, 32'h0000_AAAA);
    chk("mthi_late_lo", bus.lo, 32'h0000_0006);

    // Completion in the last permitted waiting cycle beats the timeout
    run_mul(3'd2, 32'd7, 32'd9, TIMEOUT);
    chk("edge_no_err", bus.timeout_err, 1'b0);
    chk("edge_lo", bus.lo, 32'd63);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.op_valid = ($urandom_range(0, 2) != 0);
      bus.op_code  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       bus.rs_val = 32'h8000_0000;
        1:       bus.rs_val = 32'hFFFF_FFFF;
        default: bus.rs_val = $urandom;
      endcase
      bus.rt_val = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      mdelay = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                           : $urandom_range(1, 6);
      tick();
    end
    bus.op_valid = 1'b0;
    mdelay = 2;
    wait_idle("random_bound");

    // Timeout: stale mul_end through START, then silence
    rst = 1'b1;
    tick();
    rst = 1'b0;
    present(3'd3, 32'h1234_5678, 32'd0);
    tick();
    present(3'd4, 32'h9ABC_DEF0, 32'd0);
    tick();
    mdelay    = 0;
    end_level = 1'b1;
    present(3'd1, 32'd3, 32'd4);
    tick();
    tick();
    end_level    = 1'b0;
    bus.op_valid = 1'b0;
    wait_idle("timeout_bound");
    chk("timeout_err_set", bus.timeout_err, 1'b1);
    chk("timeout_hi", bus.hi, 32'h1234_5678);
    chk("timeout_lo", bus.lo, 32'h9ABC_DEF0);

    // Reset in the middle of a wait; the late result must be dropped
    mdelay = 10;
    present(3'd2, 32'd11, 32'd13);
    tick();
    bus.op_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_work", bus.mul_work, 1'b0);
    chk("rst_err", bus.timeout_err, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    chk("late_end_hi", bus.hi, 32'h0);
    chk("late_end_lo", bus.lo, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Sequencer between the MIPS control unit and the iterative 32x32 multiplier datapath.
- Accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO from the pipeline and owns the architectural HI/LO registers.
- Converts signed operands to magnitudes, drives the multiplier work/endSignal handshake, sign-corrects the 64-bit product, and stalls the pipeline while a multiply is in flight.

Parameters:
- TIMEOUT, 64: maximum cycles spent in WAIT for mul_end before aborting.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- Clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  instruction present this cycle
- op_code  in  3  001 MULT, 010 MULTU, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO; 000/111 ignored
- rs_val  in  32  operand A / MTHI/MTLO source
- rt_val  in  32  operand B
- stall  out  1  combinational; hold pipeline, op not accepted
- rd_val  out  32  MFHI/MFLO result, combinational
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky abort flag
- mul_work  out  1  one-cycle start pulse to multiplier
- mul_lhs  out  32  registered magnitude of A
- mul_rhs  out  32  registered magnitude of B
- mul_result  in  64  unsigned product from multiplier
- mul_end  in  1  multiplier done
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Clock/reset: one clock, Clk; reset is synchronous and active-high.
- Reset values: state IDLE; hi, lo, mul_lhs, mul_rhs, internal product reg = 0; mul_work, timeout_err, busy = 0.
- Reset has priority in any state, including mid-WAIT: the in-flight multiply is dropped.
- FSM states: IDLE, START, WAIT, FIX.
- IDLE:
  - op_valid with MULT/MULTU: latch mul_lhs/mul_rhs and neg flag, go to START; stall=0 that cycle.
  - MULTU: operands passed unchanged, neg=0.
  - MULT: mul_lhs=|rs|, mul_rhs=|rt| (two's-complement negate when bit31 set; 0x80000000 stays 0x80000000), neg=rs[31]^rt[31].
  - MTHI/MTLO: write rs_val into hi/lo at this edge.
  - MFHI/MFLO: rd_val = hi/lo combinationally; stall=0.
  - rd_val = 0 for any other op.
- START: mul_work=1 for exactly this cycle; clear wait counter; next state WAIT.
- WAIT:
  - mul_work=0; counter increments each cycle.
  - mul_end is ignored during START, so a stale high level from the prior operation never completes WAIT.
  - mul_end=1 in WAIT: capture mul_result into the product reg, go to FIX.
  - counter reaches TIMEOUT with mul_end=0: set timeout_err, hi/lo unchanged, go to IDLE.
  - mul_end=1 in the same cycle the counter reaches TIMEOUT: completion wins, no error.
- FIX: hi:lo = neg ? (~prod + 1) : prod, as 64-bit two's complement; go to IDLE. New hi/lo are visible the cycle IDLE is re-entered.
- Latency: op accepted at cycle N; START N+1; WAIT from N+2; mul_end at cycle M gives FIX at M+1 and hi/lo updated at M+2.
- Stall:
  - stall = op_valid & busy & op_code in {001..110}. The op is not consumed and must be re-presented.
  - Invalid op codes never stall.
  - A MULT following a MULT stalls until IDLE.
- timeout_err is cleared only by reset.
- Multiplier outputs mul_lhs/mul_rhs are held stable from START until the next accepted multiply.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, model returns the unsigned product 2 cycles after mul_work -> mul_work is a single pulse at N+1; hi=0xFFFFFFFE, lo=0x00000001 at M+2; busy falls at M+2.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> mul_lhs=3, mul_rhs=7; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT rs=rt=0x80000000 -> mul_lhs=mul_rhs=0x80000000, neg=0; hi=0x40000000, lo=0x00000000.
- MULT, then MFLO presented every cycle -> stall=1 from N+1 through M+1; at M+2 stall=0 and rd_val equals the new lo. MTHI while busy also stalls, and hi is unchanged until accepted.
- Model holds mul_end high during START, then low forever -> no early completion; timeout_err=1 after 64 WAIT cycles; hi/lo keep prior values (0x12345678/0x9ABCDEF0 preloaded via MTHI/MTLO); FSM returns to IDLE.
- Reset asserted mid-WAIT -> next cycle state IDLE, busy=0, hi=lo=0, mul_work=0; a late mul_end pulse afterwards causes no hi/lo write.
